gray_code_stream_converter: RTL

//  - Pipelined streaming converter between Gray and binary codes, with mode selected per beat.
//  - Valid/ready handshake on both sides; full throughput of 1 beat/clk with STAGES-cycle latency.
//  - Sits between async-FIFO pointer/counter domains and binary consumers.
//  - Optional step checker flags Gray inputs that are not single-bit-step sequences.

---
 rtl/gray_code_stream_converter.sv | 159 +++++++++++++++
 1 files changed

// File: rtl/gray_code_stream_converter.sv
// ---------------------------------------------------------------------------
// gray_code_stream_converter
//
// Purpose:
//   Pipelined streaming converter between Gray and binary codes. The mode is
//   selected per beat. A valid/ready handshake runs on both sides. The
//   converter moves one beat per clock, with a latency of STAGES cycles.
//   Each stall cycle adds one cycle of latency.
//
// Parameters:
//   WIDTH   code width in bits (>= 2)
//   STAGES  register stages (1..WIDTH). This is also the latency in cycles.
//
// Ports:
//   clk        rising-edge clock
//   resetn     synchronous reset, active-low
//   in_valid   input beat valid
//   in_ready   converter accepts a beat this cycle
//   in_mode    0 = Gray->binary, 1 = binary->Gray
//   in_data    code to convert
//   out_valid  output beat valid
//   out_ready  downstream accepts the beat
//   out_mode   in_mode carried along with the beat
//   out_data   converted code
//   step_err   Gray step-check flag carried along with the beat
//
// Build option:
//   GRAY_STEP_CHECK_EN  When defined, each accepted Gray->binary input is
//                       compared with the previous one. The beat is flagged
//                       when more than one bit changed. When undefined,
//                       step_err is tied to 0. The data path is the same in
//                       both builds.
// ---------------------------------------------------------------------------
module gray_code_stream_converter #(
   parameter int WIDTH  = 4,
   parameter int STAGES = 2
) (
   input  logic             clk,
   input  logic             resetn,
   input  logic             in_valid,
   output logic             in_ready,
   input  logic             in_mode,
   input  logic [WIDTH-1:0] in_data,
   output logic             out_valid,
   input  logic             out_ready,
   output logic             out_mode,
   output logic [WIDTH-1:0] out_data,
   output logic             step_err
);

   // Returns the stage that resolves bit i of the Gray->binary prefix chain.
   // Bit WIDTH-1 is already binary. The remaining bits are dealt out
   // MSB-first, as evenly as possible. As a result, a stage's chain only
   // needs bits that the same stage or an earlier stage has already finished.
   function automatic int bit_stage(input int i);
      return ((WIDTH - 1 - i) * STAGES) / WIDTH;
   endfunction

   // Computes the partial conversion that stage s applies to the word w.
   // Binary->Gray is a single XOR level, so stage 0 does all of it and the
   // later stages only carry the result.
   function automatic logic [WIDTH-1:0] stage_fn(input logic [WIDTH-1:0] w,
                                                 input logic             mode,
                                                 input int               s);
      logic [WIDTH-1:0] r;
      r = w;
      if (mode) begin
         if (s == 0) r = w ^ (w >> 1);
      end else begin
         for (int i = WIDTH - 2; i >= 0; i--) begin
            if (bit_stage(i) == s) r[i] = r[i+1] ^ r[i];
         end
      end
      return r;
   endfunction

   logic adv;
   logic accept;
   logic err_in;

   // The whole pipeline moves as a single unit. It advances whenever the
   // output register is empty or the output beat is being taken.
   assign adv      = !out_valid | out_ready;
   assign in_ready = adv;
   assign accept   = in_valid & adv;

   generate
      for (genvar gi = 0; gi < STAGES; gi++) begin : stg
         logic [WIDTH-1:0] src_data;
         logic             src_mode;
         logic             src_valid;
         logic             src_err;
         logic [WIDTH-1:0] data_next;
         logic [WIDTH-1:0] data_reg;
         logic             mode_reg;
         logic             valid_reg;
         logic             err_reg;

         if (gi == 0) begin : head
            assign src_data  = in_data;
            assign src_mode  = in_mode;
            assign src_valid = accept;
            assign src_err   = err_in;
         end else begin : body
            assign src_data  = stg[gi-1].data_reg;
            assign src_mode  = stg[gi-1].mode_reg;
            assign src_valid = stg[gi-1].valid_reg;
            assign src_err   = stg[gi-1].err_reg;
         end

         assign data_next = stage_fn(src_data, src_mode, gi);

         // A bubble only clears the valid bit. The payload keeps the last
         // real beat, so nothing is sampled unless it was accepted.
         always_ff @(posedge clk) begin
            if (!resetn) begin
               valid_reg <= 1'b0;
               data_reg  <= '0;
               mode_reg  <= 1'b0;
               err_reg   <= 1'b0;
            end else if (adv) begin
               valid_reg <= src_valid;
               if (src_valid) begin
                  data_reg <= data_next;
                  mode_reg <= src_mode;
                  err_reg  <= src_err;
               end
            end
         end
      end
   endgenerate

   assign out_valid = stg[STAGES-1].valid_reg;
   assign out_data  = stg[STAGES-1].data_reg;
   assign out_mode  = stg[STAGES-1].mode_reg;
   assign step_err  = stg[STAGES-1].err_reg;

`ifdef GRAY_STEP_CHECK_EN
   logic [WIDTH-1:0] hist_reg;
   logic             hist_valid_reg;

   // A repeated code (distance 0) is legal. Wrap from the maximum code back
   // to 0 is a one-bit step, so it needs no special case.
   assign err_in = !in_mode & hist_valid_reg & ($countones(in_data ^ hist_reg) > 1);

   always_ff @(posedge clk) begin
      if (!resetn) begin
         hist_reg       <= '0;
         hist_valid_reg <= 1'b0;
      end else if (accept && !in_mode) begin
         hist_reg       <= in_data;
         hist_valid_reg <= 1'b1;
      end
   end
`else
   assign err_in = 1'b0;
`endif

endmodule
